fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; reset=0 forces reset state immediately.
REQ-004 Port: stall  input  1  downstream not accepting; freeze PC, FSM and holding register.
REQ-005 Port: redirect  input  1  taken branch/jump; load redirect_pc next edge.
REQ-006 Port: redirect_pc  input  32  redirect target address.
REQ-007 Port: imem_rdata  input  32  word read combinationally from imem_addr in the same cycle.
REQ-008 Port: imem_addr  output  32  word-aligned fetch address, bits[1:0]=00.
REQ-009 Port: pc  output  32  address of the instruction being presented.
REQ-010 Port: instr  output  32  presented instruction; compressed forms zero-extended in bits[31:16].
REQ-011 Port: instr_valid  output  1  instr/pc hold a complete instruction this cycle.
REQ-012 Port: is_compressed  output  1  presented instruction is 16-bit (low two bits != 2'b11).

Function
REQ-013 Internal state: pc register, FSM {FETCH, SPLIT}, 16-bit holding register hold.
REQ-014 FETCH, pc[1]=0: imem_addr={pc[31:2],2'b00}; half=imem_rdata[15:0].
REQ-015 FETCH, pc[1]=1: imem_addr={pc[31:2],2'b00}; half=imem_rdata[31:16].
REQ-016 FETCH, half[1:0]!=2'b11: instr={16'h0,half}, is_compressed=1, instr_valid=1, next pc=pc+2.
REQ-017 FETCH, pc[1]=0, half[1:0]=2'b11: instr=imem_rdata, is_compressed=0, instr_valid=1, next pc=pc+4.
REQ-018 FETCH, pc[1]=1, half[1:0]=2'b11: instr_valid=0, hold<=half, next state SPLIT, pc unchanged.
REQ-019 SPLIT: imem_addr={pc[31:2],2'b00}+4; instr={imem_rdata[15:0],hold}; instr_valid=1; is_compressed=0; next pc=pc+4; next state FETCH.
REQ-020 pc, state, hold update on the rising edge only when stall=0 or redirect=1.
REQ-021 Outputs remain combinational functions of the frozen state while stall=1; instr_valid may remain high.
REQ-022 Redirect priority over stall and sequential update: pc<={redirect_pc[31:1],1'b0}, state<=FETCH, hold discarded.
REQ-023 Redirect during SPLIT aborts the straddling instruction; no partial instruction ever presented.
REQ-024 Address arithmetic modulo 2^32: pc+2/pc+4 and SPLIT's next-word address wrap (0xFFFF_FFFE straddle fetches word 0x0000_0000).
REQ-025 Instruction accepted by consumer exactly on cycles with instr_valid=1 and stall=0.

Reset
REQ-026 On reset=0: pc=RESET_VECTOR with bit0 cleared, state=FETCH, hold=16'h0, independent of clk.
REQ-027 During reset: imem_addr={RESET_VECTOR[31:2],2'b00}; instr_valid, is_compressed follow REQ-014..017 from imem_rdata.
REQ-028 Reset asserted mid-SPLIT abandons the pending instruction; first post-reset fetch at RESET_VECTOR.

Configuration
REQ-029 Macro RVC_COMPRESSED_EN: when defined, behaviour per REQ-013..028.
REQ-030 Without RVC_COMPRESSED_EN: SPLIT and hold absent; imem_addr=pc; instr=imem_rdata; instr_valid=1; is_compressed=0; next pc=pc+4; redirect loads {redirect_pc[31:2],2'b00}; reset pc={RESET_VECTOR[31:2],2'b00}.

Verification
REQ-031 Reset, RESET_VECTOR=0, word0=32'h0000_0013 -> pc=0, instr=32'h0000_0013, valid=1, next pc=4.
REQ-032 Word at 0x8 = 32'h0093_4501 (c.nop 0x4501 low, 32-bit low half 0x0093 high) -> cycle1 pc=8 compressed instr=32'h0000_4501; cycle2 pc=0xA valid=0; cycle3 imem_addr=0xC, word 32'hxxxx_0000 -> instr=32'h0000_0093, pc=0xA, next pc=0xE.
REQ-033 stall=1 for 3 cycles in SPLIT -> pc, hold, instr unchanged; stall release -> single acceptance, pc advances by 4.
REQ-034 redirect=1, redirect_pc=32'h0000_0101 during SPLIT with stall=1 -> next pc=0x100, state FETCH, no straddled instruction presented.
REQ-035 pc=0xFFFF_FFFE, upper half 32-bit -> SPLIT fetches imem_addr=0x0, next pc=0x0000_0002.
REQ-036 reset pulled low mid-SPLIT without clock edge -> pc=RESET_VECTOR immediately; build without RVC_COMPRESSED_EN -> pc steps 0,4,8 regardless of instruction bits.

Source files
------------

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller with optional 16-bit (compressed) support
//
// Purpose: drives a word-aligned instruction memory address, presents one
// instruction per accepted cycle with its pc, honours stall and redirect.
// Optional feature macro: RVC_COMPRESSED_EN (mixed 16/32-bit instruction
// stream, including 32-bit instructions straddling two memory words).
// Without the macro every instruction is a 32-bit word and pc steps by 4.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   stall          consumer not accepting; pc/state/hold frozen
//   redirect       load redirect_pc on the next edge (wins over stall)
//   redirect_pc    redirect target
//   imem_rdata     word at imem_addr, combinational same cycle
//   imem_addr      word-aligned fetch address
//   pc             address of the presented instruction
//   instr          presented instruction (16-bit forms zero-extended)
//   instr_valid    instr/pc hold a complete instruction
//   is_compressed  presented instruction is 16-bit
module fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        is_compressed
);

`ifdef RVC_COMPRESSED_EN

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [15:0] r_hold;
    logic [15:0] w_hold_nxt;
    logic [15:0] w_half;
    logic        w_unused_rp;

    // pc is halfword aligned here, so bit 0 of the target is never used
    assign w_unused_rp = redirect_pc[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc    <= {RESET_VECTOR[31:1], 1'b0};
            r_state <= ST_FETCH;
            r_hold  <= 16'h0000;
        end else if (!stall || redirect) begin
            r_pc    <= w_pc_nxt;
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    always_comb begin
        w_half        = r_pc[1] ? imem_rdata[31:16] : imem_rdata[15:0];
        imem_addr     = {r_pc[31:2], 2'b00};
        instr         = 32'h0000_0000;
        instr_valid   = 1'b0;
        is_compressed = 1'b0;
        w_pc_nxt      = r_pc;
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold;

        case (r_state)
            ST_FETCH: begin
                if (w_half[1:0] != 2'b11) begin
                    instr         = {16'h0000, w_half};
                    is_compressed = 1'b1;
                    instr_valid   = 1'b1;
                    w_pc_nxt      = r_pc + 32'd2;
                end else if (!r_pc[1]) begin
                    instr         = imem_rdata;
                    instr_valid   = 1'b1;
                    w_pc_nxt      = r_pc + 32'd4;
                end else begin
                    // 32-bit instruction starts in the upper half: keep that
                    // half and finish it from the next word
                    w_hold_nxt    = w_half;
                    w_state_nxt   = ST_SPLIT;
                end
            end
            ST_SPLIT: begin
                // wraps naturally: a straddle at 0xFFFF_FFFE reads word 0
                imem_addr     = {r_pc[31:2], 2'b00} + 32'd4;
                instr         = {imem_rdata[15:0], r_hold};
                instr_valid   = 1'b1;
                w_pc_nxt      = r_pc + 32'd4;
                w_state_nxt   = ST_FETCH;
            end
            default: begin
                w_state_nxt   = ST_FETCH;
            end
        endcase

        // redirect abandons any half-collected instruction
        if (redirect) begin
            w_pc_nxt    = {redirect_pc[31:1], 1'b0};
            w_state_nxt = ST_FETCH;
            w_hold_nxt  = 16'h0000;
        end
    end

    assign pc = r_pc;

`else

    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [1:0]  w_unused_rp;

    // pc is word aligned here, so the low target bits are never used
    assign w_unused_rp = redirect_pc[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= {RESET_VECTOR[31:2], 2'b00};
        end else if (!stall || redirect) begin
            r_pc <= w_pc_nxt;
        end
    end

    always_comb begin
        w_pc_nxt = r_pc + 32'd4;
        if (redirect) begin
            w_pc_nxt = {redirect_pc[31:2], 2'b00};
        end
    end

    assign imem_addr     = r_pc;
    assign pc            = r_pc;
    assign instr         = imem_rdata;
    assign instr_valid   = 1'b1;
    assign is_compressed = 1'b0;

`endif

endmodule
